axil_cmd_sequencer: RTL



---
 rtl/axil_cmd_sequencer_pkg.sv | 36 +++
 rtl/axil_cmd_sequencer_if.sv | 48 ++++
 rtl/axil_cmd_fifo.sv | 70 +++++++
 rtl/axil_cmd_sequencer.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/axil_cmd_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axil_seq_pkg
//  Desc     : Shared types for the AXI4-Lite command sequencer: FSM state
//             encoding, response codes and the buffered command record.
//  Revision : 1.0 - initial release
// ============================================================================
package axil_seq_pkg;

   // Widths of the stored command record; the sequencer pads narrower
   // address/data buses into these fields.
   localparam int CMD_ADDR_WIDTH = 32;
   localparam int CMD_DATA_WIDTH = 32;

   // AXI response codes reported on the response channel
   localparam logic [1:0] RESP_OKAY    = 2'b00;
   localparam logic [1:0] RESP_SLVERR  = 2'b10;
   localparam logic [1:0] RESP_TIMEOUT = 2'b11;

   // Sequencer FSM states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   // One buffered host command
   typedef struct packed {
      logic                      write;
      logic [CMD_ADDR_WIDTH-1:0] addr;
      logic [CMD_DATA_WIDTH-1:0] wdata;
   } cmd_t;

endpackage
`default_nettype wire

// File: rtl/axil_cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : axil_cmd_sequencer_if
//  Desc     : Host command/response channels plus the start/completion
//             signals towards the AXI4-Lite master. The "slave" modport is
//             the sequencer's view; "master" is the surrounding environment.
//  Revision : 1.0 - initial release
// ============================================================================
interface axil_cmd_sequencer_if #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 32
);
   // host command channel
   logic                     cmd_valid;
   logic                     cmd_ready;
   logic                     cmd_write;
   logic [ADDRESS_WIDTH-1:0] cmd_addr;
   logic [DATA_WIDTH-1:0]    cmd_wdata;
   // host response channel
   logic                     rsp_valid;
   logic                     rsp_ready;
   logic                     rsp_write;
   logic [DATA_WIDTH-1:0]    rsp_rdata;
   logic [1:0]               rsp_resp;
   // master side
   logic                     start_read;
   logic                     start_write;
   logic [ADDRESS_WIDTH-1:0] address;
   logic [DATA_WIDTH-1:0]    w_data;
   logic [DATA_WIDTH-1:0]    r_data;
   logic                     txn_done;
   logic [1:0]               txn_resp;

   modport slave (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
             r_data, txn_done, txn_resp,
      output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp,
             start_read, start_write, address, w_data
   );

   modport master (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
             r_data, txn_done, txn_resp,
      input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp,
             start_read, start_write, address, w_data
   );
endinterface
`default_nettype wire

// File: rtl/axil_cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : axil_cmd_fifo
//  Desc     : Synchronous FIFO of command records. Head entry is visible
//             combinationally on dout. A push while full is dropped even if
//             a pop happens in the same cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module axil_cmd_fifo
   import axil_seq_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  wire logic                       clk,
   input  wire logic                       rst_n,
   input  wire logic                       push,
   input  wire logic                       pop,
   input  wire cmd_t                       din,
   output      cmd_t                       dout,
   output      logic                       full,
   output      logic                       empty,
   output      logic [$clog2(DEPTH):0]     count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   cmd_t          r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_push_ok;
   logic          w_pop_ok;

   assign full      = (r_count == DEPTH_C);
   assign empty     = (r_count == '0);
   assign count     = r_count;
   assign dout      = r_mem[r_rd_ptr];
   assign w_push_ok = push & ~full;
   assign w_pop_ok  = pop & ~empty;

   // Storage array; contents need no reset since empty gates every read
   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: rtl/axil_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : axil_cmd_sequencer
//  Desc     : Buffers host read/write commands and issues them one at a time
//             to an AXI4-Lite master as single-cycle start pulses, then
//             returns read data and response status to the host.
//             Optional watchdog on the WAIT state: define AXIL_CMD_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module axil_cmd_sequencer
   import axil_seq_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDRESS_WIDTH  = 32,
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 256
) (
   input wire logic              ACLK,
   input wire logic              ARESETN,
   axil_cmd_sequencer_if.slave   bus
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   // Reject parameter sets the datapath cannot represent
   if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) ||
       (TIMEOUT_CYCLES < 1) || (DATA_WIDTH > CMD_DATA_WIDTH) ||
       (ADDRESS_WIDTH > CMD_ADDR_WIDTH)) begin : g_param_check
      $error("axil_cmd_sequencer: unsupported parameter combination");
   end

   cmd_t                     w_fifo_din;
   cmd_t                     w_fifo_head;
   logic                     w_fifo_full;
   logic                     w_fifo_empty;
   logic [CW-1:0]            w_fifo_count;
   logic                     w_push;
   logic                     w_pop;

   state_t                   r_state;
   logic                     r_write;
   logic                     r_start_read;
   logic                     r_start_write;
   logic [ADDRESS_WIDTH-1:0] r_address;
   logic [DATA_WIDTH-1:0]    r_w_data;
   logic                     r_rsp_valid;
   logic                     r_rsp_write;
   logic [DATA_WIDTH-1:0]    r_rsp_rdata;
   logic [1:0]               r_rsp_resp;

`ifdef AXIL_CMD_TIMEOUT_EN
   localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
   logic [WDW-1:0]           r_wd_cnt;
`endif

   assign bus.cmd_ready = (w_fifo_count != DEPTH_C);
   assign w_push        = bus.cmd_valid & ~w_fifo_full;
   assign w_pop         = (r_state == ST_IDLE) & ~w_fifo_empty;
   assign w_fifo_din    = '{write: bus.cmd_write,
                            addr:  CMD_ADDR_WIDTH'(bus.cmd_addr),
                            wdata: CMD_DATA_WIDTH'(bus.cmd_wdata)};

   axil_cmd_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (ACLK),
      .rst_n (ARESETN),
      .push  (w_push),
      .pop   (w_pop),
      .din   (w_fifo_din),
      .dout  (w_fifo_head),
      .full  (w_fifo_full),
      .empty (w_fifo_empty),
      .count (w_fifo_count)
   );

   // Sequencer FSM with all master- and host-facing outputs registered
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_state       <= ST_IDLE;
         r_write       <= 1'b0;
         r_start_read  <= 1'b0;
         r_start_write <= 1'b0;
         r_address     <= '0;
         r_w_data      <= '0;
         r_rsp_valid   <= 1'b0;
         r_rsp_write   <= 1'b0;
         r_rsp_rdata   <= '0;
         r_rsp_resp    <= 2'b00;
`ifdef AXIL_CMD_TIMEOUT_EN
         r_wd_cnt      <= '0;
`endif
      end else begin
         // start pulses last exactly one cycle
         r_start_read  <= 1'b0;
         r_start_write <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (!w_fifo_empty) begin
                  r_write       <= w_fifo_head.write;
                  r_address     <= w_fifo_head.addr[ADDRESS_WIDTH-1:0];
                  r_w_data      <= w_fifo_head.wdata[DATA_WIDTH-1:0];
                  r_start_write <= w_fifo_head.write;
                  r_start_read  <= ~w_fifo_head.write;
                  r_state       <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
`ifdef AXIL_CMD_TIMEOUT_EN
               r_wd_cnt <= '0;
`endif
               r_state  <= ST_WAIT;
            end
            ST_WAIT: begin
               if (bus.txn_done) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_write <= r_write;
                  r_rsp_rdata <= r_write ? '0 : bus.r_data;
                  r_rsp_resp  <= bus.txn_resp;
                  r_state     <= ST_RESP;
               end
`ifdef AXIL_CMD_TIMEOUT_EN
               else if (r_wd_cnt == WD_LAST) begin
                  // master never answered: report timeout, late strobe is
                  // dropped because only WAIT listens to txn_done
                  r_rsp_valid <= 1'b1;
                  r_rsp_write <= r_write;
                  r_rsp_rdata <= '0;
                  r_rsp_resp  <= RESP_TIMEOUT;
                  r_state     <= ST_RESP;
               end else begin
                  r_wd_cnt <= r_wd_cnt + WDW'(1);
               end
`endif
            end
            ST_RESP: begin
               if (bus.rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.start_read  = r_start_read;
   assign bus.start_write = r_start_write;
   assign bus.address     = r_address;
   assign bus.w_data      = r_w_data;
   assign bus.rsp_valid   = r_rsp_valid;
   assign bus.rsp_write   = r_rsp_write;
   assign bus.rsp_rdata   = r_rsp_rdata;
   assign bus.rsp_resp    = r_rsp_resp;
endmodule
`default_nettype wire
